// File: rtl/alu_result_fifo.sv
// Result buffer behind the 8-bit ALU: holds {y, op, flags} in a DEPTH-entry FIFO and flags non-one-hot compares.
// Define ALU_RESULT_FIFO_STATS_EN to add saturating push/overflow counters.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_y,
  input  logic [1:0]               in_op,
  input  logic                     in_parity,
  input  logic                     in_overflow,
  input  logic                     in_greater,
  input  logic                     in_is_eq,
  input  logic                     in_less,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_y,
  output logic [1:0]               out_op,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     flag_err
`ifdef ALU_RESULT_FIFO_STATS_EN
  ,
  output logic [CW-1:0]            ovf_cnt,
  output logic [CW-1:0]            push_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] flags;
    logic [7:0] y;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_flag_err;
  logic              w_push;
  logic              w_pop;
  logic              w_onehot;
  entry_t            w_in;
  entry_t            w_head;

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_onehot  = ({in_greater, in_is_eq, in_less} == 3'b100) ||
                     ({in_greater, in_is_eq, in_less} == 3'b010) ||
                     ({in_greater, in_is_eq, in_less} == 3'b001);

  assign w_in.op    = in_op;
  assign w_in.flags = {in_less, in_is_eq, in_greater, in_overflow, in_parity};
  assign w_in.y     = in_y;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_y     = w_head.y;
  assign out_op    = w_head.op;
  assign out_flags = w_head.flags;
  assign count     = r_count;
  assign flag_err  = r_flag_err;

  // Storage is intentionally left unreset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_flag_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_push && !w_onehot) r_flag_err <= 1'b1;
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [CW-1:0] r_ovf_cnt;
  logic [CW-1:0] r_push_cnt;

  assign ovf_cnt  = r_ovf_cnt;
  assign push_cnt = r_push_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt  <= '0;
      r_push_cnt <= '0;
    end else begin
      if (w_push && r_push_cnt != '1)               r_push_cnt <= r_push_cnt + 1'b1;
      if (w_push && in_overflow && r_ovf_cnt != '1) r_ovf_cnt  <= r_ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized + directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int SAT   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_y = '0;
  logic [1:0]  in_op = '0;
  logic        in_parity = 1'b0, in_overflow = 1'b0, in_greater = 1'b0, in_is_eq = 1'b0, in_less = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  out_y;
  logic [1:0]  out_op;
  logic [4:0]  out_flags;
  logic [$clog2(DEPTH):0] count;
  logic        flag_err;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [CW-1:0] ovf_cnt, push_cnt;
`endif

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
    .in_parity(in_parity), .in_overflow(in_overflow), .in_greater(in_greater),
    .in_is_eq(in_is_eq), .in_less(in_less),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .out_flags(out_flags), .count(count), .flag_err(flag_err)
`ifdef ALU_RESULT_FIFO_STATS_EN
    , .ovf_cnt(ovf_cnt), .push_cnt(push_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [14:0] q[$];      // {op, flags, y}
  bit m_err = 0;
  int m_push = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] good_fl(input bit ovf, input bit par);
    logic [2:0] c;
    c = 3'b001 << $urandom_range(0, 2);
    return {c, ovf, par};
  endfunction

  task automatic model_reset();
    q.delete();
    m_err = 0; m_push = 0; m_ovf = 0;
  endtask

  // One clock: drive, check pre-edge (no fall-through, in_ready from state), clock, check post-edge.
  task automatic cyc(input bit v, input logic [7:0] y, input logic [1:0] op,
                     input logic [4:0] fl, input bit ordy);
    bit push, pop;
    int sz;
    in_valid = v; in_y = y; in_op = op; out_ready = ordy;
    {in_less, in_is_eq, in_greater, in_overflow, in_parity} = fl;
    #1;
    sz = q.size();
    chk("pre_out_valid", out_valid, sz != 0);
    chk("pre_in_ready", in_ready, sz < DEPTH);
    push = v && (sz < DEPTH);
    pop  = ordy && (sz > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back({op, fl, y});
      if ($countones(fl[4:2]) != 1) m_err = 1;
      if (m_push < SAT) m_push++;
      if (fl[1] && m_ovf < SAT) m_ovf++;
    end
    #1;
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    chk("flag_err", flag_err, m_err);
    if (q.size() != 0) begin
      chk("out_y", out_y, q[0][7:0]);
      chk("out_flags", out_flags, q[0][12:8]);
      chk("out_op", out_op, q[0][14:13]);
    end
`ifdef ALU_RESULT_FIFO_STATS_EN
    chk("push_cnt", push_cnt, m_push);
    chk("ovf_cnt", ovf_cnt, m_ovf);
`endif
  endtask

  task automatic idle(input bit ordy);
    cyc(0, 8'h00, 2'd0, 5'b00100, ordy);
  endtask

  initial begin
    logic [7:0] exp_y [4];
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flag_err", flag_err, 0);
    rst = 1'b0;
    model_reset();

    // Latency: pushed at edge N, visible only after it
    cyc(1, 8'h5A, 2'd1, 5'b01000, 0);
    chk("lat_y", out_y, 8'h5A);
    idle(1);
    chk("lat_drained", out_valid, 0);

    // Fill, refuse 5th, drain in order
    for (int i = 0; i < 4; i++) cyc(1, exp_y[i], 2'(i), 5'b00100, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    cyc(1, 8'h55, 2'd3, 5'b00100, 0);
    chk("full_5th_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_y", out_y, exp_y[i]);
      idle(1);
    end
    chk("drain_empty", out_valid, 0);

    // Steady push+pop at count=2 (pointers wrap twice)
    cyc(1, 8'hA0, 2'd0, 5'b00100, 0);
    cyc(1, 8'hA1, 2'd1, 5'b00100, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'hB0 + i), 2'(i), good_fl(0, 0), 1);
      chk("pp_count", count, 2);
    end

    // Full with push+pop: only the pop lands
    cyc(1, 8'hC0, 2'd0, 5'b00100, 0);
    cyc(1, 8'hC1, 2'd0, 5'b00100, 0);
    chk("pp_full", count, 4);
    cyc(1, 8'hC2, 2'd2, 5'b00100, 1);
    chk("pp_full_pop_only", count, 3);
    repeat (3) idle(1);

    // Flag packing
    cyc(1, 8'h01, 2'd2, 5'b00101, 0);
    chk("pack_flags", out_flags, 5'b00101);
    idle(1);

    // Sticky flag error
    cyc(1, 8'h02, 2'd0, 5'b01100, 1);
    chk("err_set", flag_err, 1);
    for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), 2'($urandom), good_fl(0, 1), 1);
    chk("err_sticky", flag_err, 1);
    idle(1);

    // Async reset mid-stream at count=3
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hD0 + i), 2'd0, 5'b00010, 0);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_flag_err", flag_err, 0);
`ifdef ALU_RESULT_FIFO_STATS_EN
    chk("arst_push_cnt", push_cnt, 0);
`endif
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef ALU_RESULT_FIFO_STATS_EN
    // Saturation: 300 pushes, 260 with overflow
    for (int i = 0; i < 300; i++) cyc(1, 8'($urandom), 2'($urandom), good_fl(i < 260, 0), 1);
    chk("sat_push_cnt", push_cnt, SAT);
    chk("sat_ovf_cnt", ovf_cnt, SAT);
    idle(1);
`endif

    // Random traffic, occasional bad compare flags
    for (int i = 0; i < 500; i++) begin
      logic [4:0] fl;
      fl = ($urandom_range(0, 31) == 0) ? 5'($urandom) : good_fl(1'($urandom), 1'($urandom));
      cyc(1'($urandom), 8'($urandom), 2'($urandom), fl, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
